ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_pkg.sv | 39 +++
 rtl/ahb_slave_mem_if.sv | 26 ++
 rtl/ahb_byte_lanes.sv | 26 ++
 rtl/ahb_slave_mem.sv | 102 ++++++++++
 tb/tb_ahb_slave_mem.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings, response codes and slave FSM state type
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif

package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slv_state_e;

endpackage

// File: rtl/ahb_slave_mem_if.sv
// rtl/ahb_slave_mem_if.sv - AHB slave-side bus bundle with master/slave views
interface ahb_slave_mem_if #(
    parameter int DATA_WIDTH = `AHB_DATA_WIDTH,
    parameter int ADDR_WIDTH = `AHB_ADDR_WIDTH
) ();
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_byte_lanes.sv
// rtl/ahb_byte_lanes.sv - byte-enable mask and alignment/size flags from hsize and haddr low bits
module ahb_byte_lanes #(
    parameter  int DATA_WIDTH = `AHB_DATA_WIDTH,
    localparam int BYTES      = DATA_WIDTH / 8,
    localparam int LB         = $clog2(BYTES)
) (
    input  logic [2:0]       i_size,
    input  logic [LB-1:0]    i_addr_lo,
    output logic [BYTES-1:0] o_be,
    output logic             o_misalign,
    output logic             o_oversize
);
    int w_nbytes;
    int w_lo;

    always_comb begin
        w_nbytes   = 1 << i_size;
        w_lo       = int'(i_addr_lo);
        o_oversize = w_nbytes > BYTES;
        o_misalign = (w_lo & (w_nbytes - 1)) != 0;
        o_be       = '0;
        for (int b = 0; b < BYTES; b++) begin
            o_be[b] = (b >= w_lo) && (b < w_lo + w_nbytes);
        end
    end
endmodule

// File: rtl/ahb_slave_mem.sv
// rtl/ahb_slave_mem.sv - AHB memory slave with programmable wait states and two-cycle ERROR response
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DATA_WIDTH  = `AHB_DATA_WIDTH,
    parameter int ADDR_WIDTH  = `AHB_ADDR_WIDTH,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rstn,
    ahb_slave_mem_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IW    = $clog2(MEM_DEPTH);

    slv_state_e            r_state;
    slv_state_e            w_next;
    logic [3:0]            r_cnt;
    logic                  r_pend;
    logic                  r_write;
    logic [IW-1:0]         r_idx;
    logic [BYTES-1:0]      r_be;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_active;
    logic                  w_take;
    logic                  w_err;
    logic                  w_oor;
    logic                  w_misalign;
    logic                  w_oversize;
    logic                  w_done;
    logic                  w_hreadyout;
    logic [BYTES-1:0]      w_be;

    ahb_byte_lanes #(.DATA_WIDTH(DATA_WIDTH)) u_lanes (
        .i_size     (bus.hsize),
        .i_addr_lo  (bus.haddr[LB-1:0]),
        .o_be       (w_be),
        .o_misalign (w_misalign),
        .o_oversize (w_oversize)
    );

    // Range check uses the full address so out-of-range words never alias into memory.
    assign w_oor       = (bus.haddr >> LB) >= ADDR_WIDTH'(MEM_DEPTH);
    assign w_err       = w_oor || w_misalign || w_oversize;
    assign w_active    = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);
    assign w_hreadyout = (r_state != ST_WAIT) && (r_state != ST_ERR1);
    assign w_take      = bus.hsel && bus.hready && w_hreadyout && w_active;
    assign w_done      = (r_state == ST_IDLE) && r_pend;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT: if (r_cnt == 4'd1) w_next = ST_IDLE;
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
        if (w_take) begin
            if (w_err)                w_next = ST_ERR1;
            else if (WAIT_STATES > 0) w_next = ST_WAIT;
            else                      w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_pend  <= 1'b0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_be    <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_pend  <= !w_err;
                r_write <= bus.hwrite;
                r_idx   <= bus.haddr[LB +: IW];
                r_be    <= w_be;
                r_cnt   <= w_err ? 4'd0 : 4'(WAIT_STATES);
            end else begin
                if (w_hreadyout) r_pend <= 1'b0;
                if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Writes land at the end of the completing data phase, so a read issued alongside sees them next cycle.
    always_ff @(posedge clk) begin
        if (rstn && w_done && r_write) begin
            for (int b = 0; b < BYTES; b++) begin
                if (r_be[b]) r_mem[r_idx][b*8 +: 8] <= bus.hwdata[b*8 +: 8];
            end
        end
    end

    assign bus.hreadyout = w_hreadyout;
    assign bus.hresp     = ((r_state == ST_ERR1) || (r_state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.hrdata    = (w_done && !r_write) ? r_mem[r_idx] : '0;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb/tb_ahb_slave_mem.sv - scoreboard bench for ahb_slave_mem with zero and two wait states
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    always #5 clk = ~clk;

    int          m_dut = 0;
    logic        m_hsel = 1'b0;
    logic [1:0]  m_htrans = 2'd0;
    logic        m_hwrite = 1'b0;
    logic [31:0] m_haddr = 32'd0;
    logic [2:0]  m_hsize = 3'd2;
    logic [31:0] m_hwdata = 32'd0;
    logic [31:0] m_wd_next = 32'd0;
    logic        r_blk = 1'b0;

    ahb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if0 ();
    ahb_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if1 ();

    assign if0.hsel   = m_hsel && (m_dut == 0);
    assign if0.haddr  = m_haddr;
    assign if0.htrans = m_htrans;
    assign if0.hwrite = m_hwrite;
    assign if0.hsize  = m_hsize;
    assign if0.hwdata = m_hwdata;
    assign if0.hready = r_blk ? 1'b0 : if0.hreadyout;
    assign if1.hsel   = m_hsel && (m_dut == 1);
    assign if1.haddr  = m_haddr;
    assign if1.htrans = m_htrans;
    assign if1.hwrite = m_hwrite;
    assign if1.hsize  = m_hsize;
    assign if1.hwdata = m_hwdata;
    assign if1.hready = r_blk ? 1'b0 : if1.hreadyout;

    ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .bus(if0.slave));
    ahb_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut1 (
        .clk(clk), .rstn(rstn), .bus(if1.slave));

    typedef struct {
        logic        wr;
        logic        err;
        logic [31:0] rdexp;
        logic [31:0] wdata;
        logic [7:0]  idx;
        logic [1:0]  lo;
        logic [2:0]  sz;
    } ent_t;

    ent_t        q[$];
    int          n_total = 0;
    int          n_bad = 0;
    int          stall_cnt = 0;
    logic        acc_flag = 1'b0;
    logic [31:0] mdl [2][256];
    int          ws_of [2] = '{0, 2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut=%0d got=%h exp=%h t=%0t", tag, m_dut, got, exp, $time);
        end
    endtask

    task automatic score();
        logic        rdy;
        logic        resp;
        logic        hr;
        logic [31:0] rdata;
        logic [31:0] bm;
        logic [31:0] word;
        ent_t        e;
        rdy   = (m_dut == 0) ? if0.hreadyout : if1.hreadyout;
        resp  = (m_dut == 0) ? if0.hresp     : if1.hresp;
        rdata = (m_dut == 0) ? if0.hrdata    : if1.hrdata;
        hr    = (m_dut == 0) ? if0.hready    : if1.hready;
        if (q.size() > 0) begin
            e = q[0];
            if (!rdy) begin
                stall_cnt++;
                chk("stall_resp", 32'(resp), 32'(e.err));
                chk("stall_rdata", rdata, 32'd0);
            end else begin
                chk("stall_count", 32'(stall_cnt), e.err ? 32'd1 : 32'(ws_of[m_dut]));
                chk("resp", 32'(resp), 32'(e.err));
                chk("rdata", rdata, (e.wr || e.err) ? 32'd0 : e.rdexp);
                if (e.wr && !e.err) begin
                    bm   = ((32'd1 << (32'd1 << e.sz)) - 32'd1) << e.lo;
                    word = mdl[m_dut][e.idx];
                    for (int b = 0; b < 4; b++) begin
                        if (bm[b]) word[b*8 +: 8] = e.wdata[b*8 +: 8];
                    end
                    mdl[m_dut][e.idx] = word;
                end
                void'(q.pop_front());
                stall_cnt = 0;
            end
        end else begin
            chk("idle_rdy", 32'(rdy), 32'd1);
            chk("idle_resp", 32'(resp), 32'd0);
            chk("idle_rdata", rdata, 32'd0);
        end
        acc_flag = m_hsel && hr && m_htrans[1];
        if (acc_flag) begin
            e.wr    = m_hwrite;
            e.sz    = m_hsize;
            e.lo    = m_haddr[1:0];
            e.idx   = m_haddr[9:2];
            e.err   = ((m_haddr >> 2) >= 32'd256) || ((m_haddr & ((32'd1 << m_hsize) - 32'd1)) != 32'd0)
                      || ((32'd1 << m_hsize) > 32'd4);
            e.wdata = m_wd_next;
            e.rdexp = (e.err || m_hwrite) ? 32'd0 : mdl[m_dut][e.idx];
            q.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rstn) score();
        @(posedge clk);
        #1;
        m_hwdata = (q.size() > 0) ? q[0].wdata : 32'd0;
    endtask

    task automatic drive(input int d, input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        m_dut = d; m_hsel = sel; m_htrans = tr; m_hwrite = wr;
        m_haddr = a; m_hsize = sz; m_wd_next = wd;
        tick();
    endtask

    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd);
        for (int k = 0; k < 20; k++) begin
            drive(d, 1'b1, HTRANS_NONSEQ, wr, a, sz, wd);
            if (acc_flag) break;
        end
        chk("accepted", 32'(acc_flag), 32'd1);
    endtask

    task automatic idle(input int d, input int n);
        m_dut = d; m_hsel = 1'b0; m_htrans = HTRANS_IDLE; m_hwrite = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        rstn = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_rdy0", 32'(if0.hreadyout), 32'd1);
        chk("rst_resp0", 32'(if0.hresp), 32'd0);
        chk("rst_rdata0", if0.hrdata, 32'd0);
        chk("rst_rdy1", 32'(if1.hreadyout), 32'd1);
        chk("rst_resp1", 32'(if1.hresp), 32'd0);
        chk("rst_rdata1", if1.hrdata, 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // zero wait states: back-to-back write/read, byte and halfword lanes
        xfer(0, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
        xfer(0, 1'b1, 32'h20, HSIZE_WORD, 32'h11223344);
        xfer(0, 1'b1, 32'h21, HSIZE_BYTE, 32'h0000AB00);
        xfer(0, 1'b0, 32'h20, HSIZE_WORD, 32'h0);
        xfer(0, 1'b1, 32'h22, HSIZE_HALF, 32'h55660000);
        xfer(0, 1'b0, 32'h20, HSIZE_WORD, 32'h0);
        xfer(0, 1'b1, 32'h00, HSIZE_WORD, 32'hCAFEF00D);
        idle(0, 2);

        // errors: out of range, misaligned, oversize; memory must stay intact
        xfer(0, 1'b0, 32'h400, HSIZE_WORD, 32'h0);
        xfer(0, 1'b1, 32'h02, HSIZE_WORD, 32'hFFFFFFFF);
        xfer(0, 1'b1, 32'h400, HSIZE_WORD, 32'h12121212);
        xfer(0, 1'b0, 32'h08, HSIZE_DWORD, 32'h0);
        xfer(0, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        idle(0, 2);

        // BUSY and hready-gated NONSEQ must be ignored
        drive(0, 1'b1, HTRANS_BUSY, 1'b1, 32'h00, HSIZE_WORD, 32'h0);
        r_blk = 1'b1;
        drive(0, 1'b1, HTRANS_NONSEQ, 1'b1, 32'h00, HSIZE_WORD, 32'h0);
        r_blk = 1'b0;
        idle(0, 1);
        xfer(0, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
        xfer(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0);
        idle(0, 2);

        // two wait states
        xfer(1, 1'b1, 32'h04, HSIZE_WORD, 32'h0BADC0DE);
        xfer(1, 1'b0, 32'h04, HSIZE_WORD, 32'h0);
        xfer(1, 1'b1, 32'h08, HSIZE_WORD, 32'h12345678);
        xfer(1, 1'b1, 32'h09, HSIZE_BYTE, 32'h0000EE00);
        xfer(1, 1'b0, 32'h08, HSIZE_WORD, 32'h0);
        xfer(1, 1'b0, 32'h400, HSIZE_WORD, 32'h0);
        xfer(1, 1'b0, 32'h04, HSIZE_WORD, 32'h0);
        idle(1, 5);

        // reset while a write sits in WAIT: it must be dropped
        xfer(1, 1'b1, 32'h08, HSIZE_WORD, 32'hFFFF0000);
        idle(1, 1);
        rstn = 1'b0;
        tick();
        q.delete();
        stall_cnt = 0;
        rstn = 1'b1;
        m_hwdata = 32'hFFFF0000;
        idle(1, 2);
        xfer(1, 1'b0, 32'h08, HSIZE_WORD, 32'h0);
        idle(1, 5);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
